// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - ALU operation decode plus DEPTH-entry in-order issue buffer.
// Ops are decoded at acceptance; the head entry is presented to the ALU with a valid/ready handshake.
module alu_issue #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_aluop,
    input  logic [5:0]  in_funct,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_a,
    output logic [31:0] out_b,
    output logic [3:0]  out_f,
    output logic        out_ill,
    output logic [7:0]  ill_cnt
);

    localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [31:0] a_mem [DEPTH];
    logic [31:0] b_mem [DEPTH];
    logic [4:0]  fi_mem [DEPTH];

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic [7:0]    ill_cnt_q, ill_cnt_d;

    logic [3:0] dec_f;
    logic       dec_ill;
    logic       push, pop;

    // Illegal ops still carry a harmless add code so the ALU never sees an undefined function.
    always_comb begin
        dec_f   = 4'b0010;
        dec_ill = 1'b0;
        case (in_aluop)
            2'b00: dec_f = 4'b0010;
            2'b01: dec_f = 4'b0110;
            2'b10: begin
                case (in_funct)
                    6'b100000: dec_f = 4'b0010;
                    6'b100010: dec_f = 4'b0110;
                    6'b100100: dec_f = 4'b0000;
                    6'b100101: dec_f = 4'b0001;
                    6'b101010: dec_f = 4'b0111;
                    default:   dec_ill = 1'b1;
                endcase
            end
            default: dec_ill = 1'b1;
        endcase
    end

    assign in_ready  = (count_q < DEPTH_C);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        wptr_d    = push ? wptr_q + PTR_ONE : wptr_q;
        rptr_d    = pop ? rptr_q + PTR_ONE : rptr_q;
        count_d   = count_q;
        ill_cnt_d = ill_cnt_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        if (push && dec_ill && (ill_cnt_q != 8'hFF)) begin
            ill_cnt_d = ill_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            ill_cnt_q <= '0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            ill_cnt_q <= ill_cnt_d;
        end
    end

    // Entry storage needs no reset: an empty buffer masks it at the outputs.
    always_ff @(posedge clk) begin
        if (push) begin
            a_mem[wptr_q]  <= in_a;
            b_mem[wptr_q]  <= in_b;
            fi_mem[wptr_q] <= {dec_f, dec_ill};
        end
    end

    assign out_a   = out_valid ? a_mem[rptr_q] : 32'd0;
    assign out_b   = out_valid ? b_mem[rptr_q] : 32'd0;
    assign out_f   = out_valid ? fi_mem[rptr_q][4:1] : 4'd0;
    assign out_ill = out_valid ? fi_mem[rptr_q][0] : 1'b0;
    assign ill_cnt = ill_cnt_q;

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - directed self-checking bench for alu_issue.
module tb_alu_issue;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_aluop;
    logic [5:0]  in_funct;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [3:0]  out_f;
    logic        out_ill;
    logic [7:0]  ill_cnt;

    int n_assert;
    int n_fail;

    alu_issue #(.DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_aluop(in_aluop), .in_funct(in_funct),
        .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_f(out_f), .out_ill(out_ill),
        .ill_cnt(ill_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b);
        in_valid = v;
        in_aluop = op;
        in_funct = fn;
        in_a     = a;
        in_b     = b;
    endtask

    logic [1:0]  t_op  [9];
    logic [5:0]  t_fn  [9];
    logic [3:0]  t_f   [9];
    logic        t_ill [9];

    initial begin
        n_assert = 0;
        n_fail   = 0;
        t_op[0] = 2'b00; t_fn[0] = 6'b000000; t_f[0] = 4'b0010; t_ill[0] = 1'b0;
        t_op[1] = 2'b01; t_fn[1] = 6'b100101; t_f[1] = 4'b0110; t_ill[1] = 1'b0;
        t_op[2] = 2'b10; t_fn[2] = 6'b100000; t_f[2] = 4'b0010; t_ill[2] = 1'b0;
        t_op[3] = 2'b10; t_fn[3] = 6'b100010; t_f[3] = 4'b0110; t_ill[3] = 1'b0;
        t_op[4] = 2'b10; t_fn[4] = 6'b100100; t_f[4] = 4'b0000; t_ill[4] = 1'b0;
        t_op[5] = 2'b10; t_fn[5] = 6'b100101; t_f[5] = 4'b0001; t_ill[5] = 1'b0;
        t_op[6] = 2'b10; t_fn[6] = 6'b101010; t_f[6] = 4'b0111; t_ill[6] = 1'b0;
        t_op[7] = 2'b10; t_fn[7] = 6'b111111; t_f[7] = 4'b0010; t_ill[7] = 1'b1;
        t_op[8] = 2'b11; t_fn[8] = 6'b100000; t_f[8] = 4'b0010; t_ill[8] = 1'b1;

        // Reset state
        rst_n = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_a", out_a, 32'd0);
        chk("rst_out_f", 32'(out_f), 32'd0);
        chk("rst_ill_cnt", 32'(ill_cnt), 32'd0);
        tick();
        rst_n = 1'b1;

        // Single slt op, pushed on the first edge after reset release
        out_ready = 1'b1;
        drive(1'b1, 2'b10, 6'b101010, 32'd5, 32'd9);
        tick();
        drive(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
        chk("slt_valid", 32'(out_valid), 32'd1);
        chk("slt_f", 32'(out_f), 32'h7);
        chk("slt_a", out_a, 32'd5);
        chk("slt_b", out_b, 32'd9);
        chk("slt_ill", 32'(out_ill), 32'd0);
        tick();
        chk("slt_drained", 32'(out_valid), 32'd0);

        // Fill with and/or, sub held by upstream while full
        out_ready = 1'b0;
        drive(1'b1, 2'b10, 6'b100100, 32'd1, 32'd2);
        tick();
        chk("fill1_in_ready", 32'(in_ready), 32'd1);
        chk("fill1_f", 32'(out_f), 32'h0);
        drive(1'b1, 2'b10, 6'b100101, 32'd3, 32'd4);
        tick();
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_head_a", out_a, 32'd1);
        drive(1'b1, 2'b01, 6'b000000, 32'd6, 32'd7);
        tick();
        chk("stall_f", 32'(out_f), 32'h0);
        chk("stall_b", out_b, 32'd2);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        tick();
        chk("full_pop_f", 32'(out_f), 32'h1);
        chk("full_pop_a", out_a, 32'd3);
        chk("full_pop_in_ready", 32'(in_ready), 32'd1);
        tick();
        drive(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
        chk("pushpop_f", 32'(out_f), 32'h6);
        chk("pushpop_a", out_a, 32'd6);
        chk("pushpop_b", out_b, 32'd7);
        chk("pushpop_in_ready", 32'(in_ready), 32'd1);
        chk("pushpop_valid", 32'(out_valid), 32'd1);
        tick();
        chk("order_drained", 32'(out_valid), 32'd0);
        chk("empty_f", 32'(out_f), 32'd0);

        // Full decode table, one op per cycle with continuous pop
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, t_op[i], t_fn[i], 32'(i * 3 + 1), ~32'(i * 3 + 1));
            tick();
            chk($sformatf("dec%0d_f", i), 32'(out_f), 32'(t_f[i]));
            chk($sformatf("dec%0d_ill", i), 32'(out_ill), 32'(t_ill[i]));
            chk($sformatf("dec%0d_a", i), out_a, 32'(i * 3 + 1));
            chk($sformatf("dec%0d_b", i), out_b, ~32'(i * 3 + 1));
        end
        drive(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
        chk("dec_ill_cnt", 32'(ill_cnt), 32'd2);
        tick();
        chk("dec_drained", 32'(out_valid), 32'd0);

        // Illegal ops and saturating counter
        out_ready = 1'b0;
        drive(1'b1, 2'b10, 6'b000000, 32'd8, 32'd0);
        tick();
        chk("ill1_flag", 32'(out_ill), 32'd1);
        chk("ill1_f", 32'(out_f), 32'h2);
        chk("ill1_cnt", 32'(ill_cnt), 32'd3);
        drive(1'b1, 2'b11, 6'b100000, 32'd9, 32'd0);
        tick();
        drive(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
        chk("ill2_cnt", 32'(ill_cnt), 32'd4);
        out_ready = 1'b1;
        tick();
        chk("ill2_flag", 32'(out_ill), 32'd1);
        chk("ill2_f", 32'(out_f), 32'h2);
        chk("ill2_a", out_a, 32'd9);
        tick();
        chk("ill_drained", 32'(out_valid), 32'd0);
        drive(1'b1, 2'b11, 6'd0, 32'd0, 32'd0);
        for (int i = 0; i < 250; i++) tick();
        chk("ill_cnt_254", 32'(ill_cnt), 32'd254);
        tick();
        chk("ill_cnt_255", 32'(ill_cnt), 32'd255);
        for (int i = 0; i < 49; i++) tick();
        chk("ill_cnt_sat", 32'(ill_cnt), 32'd255);
        drive(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
        tick();

        // Asynchronous reset while full
        out_ready = 1'b0;
        drive(1'b1, 2'b00, 6'd0, 32'd1, 32'd1);
        tick();
        tick();
        drive(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
        chk("prerst_in_ready", 32'(in_ready), 32'd0);
        chk("prerst_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_ill_cnt", 32'(ill_cnt), 32'd0);
        chk("arst_out_a", out_a, 32'd0);
        chk("arst_out_f", 32'(out_f), 32'd0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("postrst_valid", 32'(out_valid), 32'd0);
        chk("postrst_ill", 32'(out_ill), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have parameter DEPTH, default 2, buffer entries; legal values are powers of two >= 2.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  upstream offers an operation.
REQ-005 SHALL have port in_ready  output  1  block can accept an operation this cycle.
REQ-006 SHALL have port in_aluop  input  2  main-decoder ALU class.
REQ-007 SHALL have port in_funct  input  6  R-type funct field.
REQ-008 SHALL have port in_a  input  32  operand A.
REQ-009 SHALL have port in_b  input  32  operand B.
REQ-010 SHALL have port out_valid  output  1  head entry presented to ALU.
REQ-011 SHALL have port out_ready  input  1  downstream consumes head entry.
REQ-012 SHALL have port out_a  output  32  ALU operand A.
REQ-013 SHALL have port out_b  output  32  ALU operand B.
REQ-014 SHALL have port out_f  output  4  ALU function code; bit 3 always 0.
REQ-015 SHALL have port out_ill  output  1  head entry carries an illegal operation.
REQ-016 SHALL have port ill_cnt  output  8  count of accepted illegal operations.

Function
REQ-017 SHALL decode at acceptance: aluop 00 -> f=0010 (add); aluop 01 -> f=0110 (sub); aluop 10 -> funct decode; aluop 11 -> illegal.
REQ-018 SHALL decode funct: 100000 -> 0010, 100010 -> 0110, 100100 -> 0000, 100101 -> 0001, 101010 -> 0111; any other funct -> illegal.
REQ-019 SHALL store an illegal op with f=0010 and ill flag 1; legal ops store ill flag 0.
REQ-020 SHALL accept (push) on a rising edge when in_valid=1 and in_ready=1, storing {a, b, f, ill} at the tail.
REQ-021 SHALL pop the head on a rising edge when out_valid=1 and out_ready=1.
REQ-022 SHALL drive in_ready = (count < DEPTH), combinational from registered count only; no path from in_valid or out_ready.
REQ-023 SHALL drive out_valid = (count != 0), registered-state only.
REQ-024 SHALL present head entry on out_a/out_b/out_f/out_ill; when count=0 these SHALL be all zero.
REQ-025 SHALL have latency 1: op accepted on edge N into empty buffer is presented with out_valid=1 after edge N.
REQ-026 SHALL preserve order (FIFO); no entry dropped or duplicated.
REQ-027 SHALL, on simultaneous push and pop, keep count unchanged and advance both pointers; valid at any count 1..DEPTH-1.
REQ-028 SHALL, when full, refuse pushes (in_ready=0) even if a pop occurs the same cycle; pop still completes.
REQ-029 SHALL, when empty, ignore out_ready (no pop, no pointer change).
REQ-030 SHALL wrap read/write pointers modulo DEPTH.
REQ-031 SHALL increment ill_cnt by 1 on each accepted illegal op, saturating at 255.
REQ-032 SHALL hold outputs stable while out_valid=1 and out_ready=0.

Reset
REQ-033 SHALL, while rst_n=0, asynchronously clear count, pointers, ill_cnt to 0; out_valid=0, in_ready=1, out_a/out_b/out_f/out_ill=0.
REQ-034 SHALL discard all buffered entries on reset asserted mid-operation; no entry appears after release.
REQ-035 SHALL accept a push on the first rising edge after rst_n deasserts.

Verification
REQ-036 Reset then aluop=10, funct=101010, a=5, b=9, in_valid=1 one cycle, out_ready=1 -> next cycle out_valid=1, out_f=0111, out_a=5, out_b=9, out_ill=0; following cycle out_valid=0.
REQ-037 out_ready=0, push three ops (and, or, sub) back-to-back -> in_ready=0 after second push, third held by upstream; outputs show 'and' (f=0000) stably; out_ready=1 -> order 0000, 0001, 0110.
REQ-038 count=1, push and pop same edge -> count stays 1, out_f switches to new entry, no loss.
REQ-039 aluop=10, funct=000000 and aluop=11 accepted -> out_ill=1, out_f=0010 each; ill_cnt=2; 300 illegal pushes -> ill_cnt=255.
REQ-040 Buffer full, rst_n pulsed low mid-cycle -> out_valid=0, in_ready=1, ill_cnt=0 immediately, before next clk edge.
REQ-041 Random valid/ready stress 10000 ops vs. reference queue model -> exact order and decode match, no handshake violations.
